// File: rtl/axioma_icu_pkg.sv
// -----------------------------------------------------------------------------
// axioma_icu_pkg
// Shared constants for the AxiomaCore-328 input capture unit:
//   - register offsets relative to the unit's I/O base address
//   - bit positions inside ICCR and ICFR
//   - clock-select encodings and the matching prescaler divide values
// -----------------------------------------------------------------------------
package axioma_icu_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [2:0] OFS_ICCR  = 3'd0;
    localparam logic [2:0] OFS_ICFR  = 3'd1;
    localparam logic [2:0] OFS_ICRL  = 3'd2;
    localparam logic [2:0] OFS_ICRH  = 3'd3;
    localparam logic [2:0] OFS_TCNTL = 3'd4;
    localparam logic [2:0] OFS_TCNTH = 3'd5;
    localparam logic [5:0] NUM_REGS  = 6'd6;

    // ICCR bit positions
    localparam int BIT_ICNC = 7;
    localparam int BIT_ICES = 6;
    localparam int BIT_ICIE = 5;
    localparam int BIT_TOIE = 4;
    localparam int BIT_CLR  = 3;

    // ICFR bit positions
    localparam int BIT_ICOVR = 2;
    localparam int BIT_TOV   = 1;
    localparam int BIT_ICF   = 0;

    // Clock-select encodings (110/111 also stop the counter)
    localparam logic [2:0] CS_STOP    = 3'b000;
    localparam logic [2:0] CS_DIV1    = 3'b001;
    localparam logic [2:0] CS_DIV8    = 3'b010;
    localparam logic [2:0] CS_DIV64   = 3'b011;
    localparam logic [2:0] CS_DIV256  = 3'b100;
    localparam logic [2:0] CS_DIV1024 = 3'b101;

    // Divide ratio for a clock select; 0 means the counter is stopped.
    function automatic logic [10:0] cs_divide(input logic [2:0] cs);
        case (cs)
            CS_DIV1:    return 11'd1;
            CS_DIV8:    return 11'd8;
            CS_DIV64:   return 11'd64;
            CS_DIV256:  return 11'd256;
            CS_DIV1024: return 11'd1024;
            default:    return 11'd0;
        endcase
    endfunction

endpackage

// File: rtl/axioma_icp_filter.sv
// -----------------------------------------------------------------------------
// axioma_icp_filter
// Brings the asynchronous ICP pin into the clk domain and turns it into
// single-cycle edge pulses.
//   clk, reset   : system clock, synchronous active-high reset
//   icp          : raw asynchronous capture pin
//   icnc         : 1 = edges taken from the noise-cancelled level
//   rise_pulse   : one-cycle pulse on a rising edge of the selected level
//   fall_pulse   : one-cycle pulse on a falling edge of the selected level
// The canceler keeps running while icnc=0 so toggling icnc never disturbs
// its state; each level source has its own history flop so switching the
// selection cannot fabricate an edge out of two unrelated levels.
// -----------------------------------------------------------------------------
module axioma_icp_filter #(
    parameter int NC_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic icp,
    input  logic icnc,
    output logic rise_pulse,
    output logic fall_pulse
);
    import axioma_icu_pkg::*;

    localparam int CW = (NC_DEPTH > 1) ? $clog2(NC_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NC_DEPTH - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          sync_prev_reg;
    logic          filt_reg;
    logic          filt_prev_reg;
    logic [CW-1:0] cnt_reg;
    logic          level_now;
    logic          level_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg     <= 1'b0;
            sync2_reg     <= 1'b0;
            sync_prev_reg <= 1'b0;
            filt_reg      <= 1'b0;
            filt_prev_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            sync1_reg     <= icp;
            sync2_reg     <= sync1_reg;
            sync_prev_reg <= sync2_reg;
            filt_prev_reg <= filt_reg;
            // Count consecutive samples that disagree with the filtered level;
            // the NC_DEPTH-th disagreeing sample flips it.
            if (sync2_reg != filt_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    filt_reg <= sync2_reg;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level_now  = icnc ? filt_reg      : sync2_reg;
    assign level_prev = icnc ? filt_prev_reg : sync_prev_reg;
    assign rise_pulse = level_now & ~level_prev;
    assign fall_pulse = ~level_now & level_prev;

endmodule

// File: rtl/axioma_input_capture.sv
// -----------------------------------------------------------------------------
// axioma_input_capture
// 16-bit input capture unit on the AxiomaCore-328 I/O bus. Timestamps ICP
// edges against a prescaled free-running counter and raises capture and
// overflow interrupts.
//   clk, reset            : system clock, synchronous active-high reset
//   io_addr/io_data_in    : I/O address and write data
//   io_read/io_write      : one-cycle access strobes
//   io_data_out           : combinational read data (0 when idle/unmapped)
//   icp                   : asynchronous capture pin
//   icp_capt_irq          : ICF & ICIE
//   icp_ovf_irq           : TOV & TOIE
//   debug_tcnt/debug_icr  : live counter and capture register
// Registers at BASE_ADDR+0..5: ICCR, ICFR, ICRL, ICRH, TCNTL, TCNTH.
// -----------------------------------------------------------------------------
module axioma_input_capture #(
    parameter logic [5:0] BASE_ADDR = 6'h38,
    parameter int         NC_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  io_addr,
    input  logic [7:0]  io_data_in,
    output logic [7:0]  io_data_out,
    input  logic        io_read,
    input  logic        io_write,
    input  logic        icp,
    output logic        icp_capt_irq,
    output logic        icp_ovf_irq,
    output logic [15:0] debug_tcnt,
    output logic [15:0] debug_icr
);
    import axioma_icu_pkg::*;

    logic        icnc_reg, ices_reg, icie_reg, toie_reg;
    logic [2:0]  cs_reg;
    logic        icf_reg, tov_reg, icovr_reg;
    logic [15:0] icr_reg, tcnt_reg;
    logic [7:0]  temp_reg;
    logic [9:0]  presc_reg;

    logic [5:0]  offset;
    logic        hit;
    logic [2:0]  reg_sel;
    logic        wr_iccr, wr_icfr, rd_icrl, rd_tcntl;
    logic        clr_req, cs_change;
    logic [10:0] div, div_m1;
    logic        tick, wrap;
    logic        rise_pulse, fall_pulse, capture;

    axioma_icp_filter #(.NC_DEPTH(NC_DEPTH)) u_filter (
        .clk        (clk),
        .reset      (reset),
        .icp        (icp),
        .icnc       (icnc_reg),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // Address decode: unsigned offset from the base, mapped below NUM_REGS.
    assign offset   = io_addr - BASE_ADDR;
    assign hit      = (offset < NUM_REGS);
    assign reg_sel  = offset[2:0];
    assign wr_iccr  = io_write & hit & (reg_sel == OFS_ICCR);
    assign wr_icfr  = io_write & hit & (reg_sel == OFS_ICFR);
    assign rd_icrl  = io_read  & hit & (reg_sel == OFS_ICRL);
    assign rd_tcntl = io_read  & hit & (reg_sel == OFS_TCNTL);

    assign clr_req   = wr_iccr & io_data_in[BIT_CLR];
    assign cs_change = wr_iccr & (io_data_in[2:0] != cs_reg);

    assign div    = cs_divide(cs_reg);
    assign div_m1 = div - 11'd1;
    assign tick   = (div != 11'd0) && (presc_reg == div_m1[9:0]);
    // A CLR in the same cycle suppresses the overflow flag.
    assign wrap   = tick & (tcnt_reg == 16'hFFFF) & ~clr_req;

    assign capture = ices_reg ? rise_pulse : fall_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            icnc_reg  <= 1'b0;
            ices_reg  <= 1'b0;
            icie_reg  <= 1'b0;
            toie_reg  <= 1'b0;
            cs_reg    <= CS_STOP;
            icf_reg   <= 1'b0;
            tov_reg   <= 1'b0;
            icovr_reg <= 1'b0;
            icr_reg   <= 16'h0000;
            tcnt_reg  <= 16'h0000;
            temp_reg  <= 8'h00;
            presc_reg <= 10'd0;
        end else begin
            if (wr_iccr) begin
                icnc_reg <= io_data_in[BIT_ICNC];
                ices_reg <= io_data_in[BIT_ICES];
                icie_reg <= io_data_in[BIT_ICIE];
                toie_reg <= io_data_in[BIT_TOIE];
                cs_reg   <= io_data_in[2:0];
            end

            if (clr_req || cs_change || tick)
                presc_reg <= 10'd0;
            else if (div != 11'd0)
                presc_reg <= presc_reg + 10'd1;

            if (clr_req)
                tcnt_reg <= 16'h0000;
            else if (tick)
                tcnt_reg <= tcnt_reg + 16'd1;

            // Capture samples the counter before any same-cycle tick or clear.
            if (capture)
                icr_reg <= tcnt_reg;

            // Write-one-to-clear; a same-cycle set takes priority.
            icf_reg   <= (icf_reg   & ~(wr_icfr & io_data_in[BIT_ICF]))   | capture;
            icovr_reg <= (icovr_reg & ~(wr_icfr & io_data_in[BIT_ICOVR])) | (capture & icf_reg);
            tov_reg   <= (tov_reg   & ~(wr_icfr & io_data_in[BIT_TOV]))   | wrap;

            if (rd_icrl)
                temp_reg <= icr_reg[15:8];
            else if (rd_tcntl)
                temp_reg <= tcnt_reg[15:8];
        end
    end

    always_comb begin
        io_data_out = 8'h00;
        if (io_read && hit) begin
            case (reg_sel)
                OFS_ICCR:  io_data_out = {icnc_reg, ices_reg, icie_reg, toie_reg, 1'b0, cs_reg};
                OFS_ICFR:  io_data_out = {5'b00000, icovr_reg, tov_reg, icf_reg};
                OFS_ICRL:  io_data_out = icr_reg[7:0];
                OFS_ICRH:  io_data_out = temp_reg;
                OFS_TCNTL: io_data_out = tcnt_reg[7:0];
                OFS_TCNTH: io_data_out = temp_reg;
                default:   io_data_out = 8'h00;
            endcase
        end
    end

    assign icp_capt_irq = icf_reg & icie_reg;
    assign icp_ovf_irq  = tov_reg & toie_reg;
    assign debug_tcnt   = tcnt_reg;
    assign debug_icr    = icr_reg;

endmodule

// File: tb/tb_axioma_input_capture.sv
// -----------------------------------------------------------------------------
// tb_axioma_input_capture
// Directed sequence with randomized gaps and pulse widths. Expected counter
// values come from elapsed cycles since the last CLR divided by the prescale
// ratio; expected capture values are the counter value two cycles after the
// pin change (synchronizer) plus NC_DEPTH when the canceler is on.
// -----------------------------------------------------------------------------
module tb_axioma_input_capture;

    localparam logic [5:0] A_ICCR  = 6'h38;
    localparam logic [5:0] A_ICFR  = 6'h39;
    localparam logic [5:0] A_ICRL  = 6'h3A;
    localparam logic [5:0] A_ICRH  = 6'h3B;
    localparam logic [5:0] A_TCNTL = 6'h3C;
    localparam logic [5:0] A_TCNTH = 6'h3D;
    localparam int         NCD     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  io_addr;
    logic [7:0]  io_data_in;
    logic [7:0]  io_data_out;
    logic        io_read;
    logic        io_write;
    logic        icp;
    logic        icp_capt_irq;
    logic        icp_ovf_irq;
    logic [15:0] debug_tcnt;
    logic [15:0] debug_icr;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int clr_cyc = 0;
    int div = 1;

    axioma_input_capture #(.BASE_ADDR(6'h38), .NC_DEPTH(NCD)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_addr      (io_addr),
        .io_data_in   (io_data_in),
        .io_data_out  (io_data_out),
        .io_read      (io_read),
        .io_write     (io_write),
        .icp          (icp),
        .icp_capt_irq (icp_capt_irq),
        .icp_ovf_irq  (icp_ovf_irq),
        .debug_tcnt   (debug_tcnt),
        .debug_icr    (debug_icr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter value the reference expects right now.
    function automatic int exp_tcnt();
        return ((cyc - clr_cyc) / div) % 65536;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        io_addr    = a;
        io_data_in = d;
        io_write   = 1'b1;
        @(posedge clk);
        #1;
        io_write   = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] d);
        io_addr = a;
        io_read = 1'b1;
        #1;
        d = io_data_out;
        @(posedge clk);
        #1;
        io_read = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step(1);
    endtask

    initial begin
        logic [7:0] d;
        int c, r;

        reset = 1'b1; io_addr = '0; io_data_in = '0;
        io_read = 1'b0; io_write = 1'b0; icp = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state
        check("rst_tcnt", debug_tcnt, 16'h0);
        check("rst_icr", debug_icr, 16'h0);
        check("rst_capt_irq", icp_capt_irq, 1'b0);
        check("rst_ovf_irq", icp_ovf_irq, 1'b0);
        rd(A_ICCR, d); check("rst_iccr", d, 8'h00);
        rd(A_ICFR, d); check("rst_icfr", d, 8'h00);

        // T1: /1, rising, no canceler, CLR then an edge ~100 cycles later
        wr(A_ICCR, 8'h69); clr_cyc = cyc; div = 1;
        rd(A_ICCR, d); check("t1_iccr_clr_reads0", d, 8'h61);
        step(95 + $urandom_range(0, 10));
        icp = 1'b1; c = cyc;
        step(2); check("t1_irq_before_latency", icp_capt_irq, 1'b0);
        step(1); check("t1_irq_at_latency", icp_capt_irq, 1'b1);
        check("t1_icr", debug_icr, 32'(c + 2 - clr_cyc));
        wr(A_ICCR, 8'h41);
        check("t1_irq_follows_icie", icp_capt_irq, 1'b0);
        rd(A_ICFR, d); check("t1_icfr", d, 8'h01);
        wr(A_ICFR, 8'h01);
        rd(A_ICFR, d); check("t1_icf_cleared", d, 8'h00);

        // T2: falling edges, second one overruns
        wr(A_ICCR, 8'h01);
        icp = 1'b0;
        step(4 + $urandom_range(0, 8));
        icp = 1'b1;
        step(5 + $urandom_range(0, 8));
        icp = 1'b0; c = cyc;
        step(3);
        check("t2_icr_second", debug_icr, 32'(c + 2 - clr_cyc));
        rd(A_ICFR, d); check("t2_icovr", d, 8'h05);
        wr(A_ICFR, 8'h05);
        rd(A_ICFR, d); check("t2_cleared", d, 8'h00);

        // T3: canceler on, glitch rejected, long pulse captured NCD later
        wr(A_ICCR, 8'hE1);
        step(8);
        icp = 1'b1;
        step($urandom_range(1, NCD - 1));
        icp = 1'b0;
        step(12);
        check("t3_glitch_no_irq", icp_capt_irq, 1'b0);
        icp = 1'b1; c = cyc;
        step(2 + NCD); check("t3_irq_before_latency", icp_capt_irq, 1'b0);
        step(1); check("t3_irq_at_latency", icp_capt_irq, 1'b1);
        check("t3_icr", debug_icr, 32'(c + 2 + NCD - clr_cyc));
        step(3);
        icp = 1'b0;
        step(12);
        rd(A_ICFR, d); check("t3_single_capture", d, 8'h01);
        wr(A_ICFR, 8'h01);

        // T4 + T5: /1 ramp from CLR; timed captures, TEMP, then wrap
        wr(A_ICCR, 8'h59); clr_cyc = cyc; div = 1;
        run_to(clr_cyc + 32'h12AB - 2);
        icp = 1'b1;
        step(3); check("t5_icr_12ab", debug_icr, 16'h12AB);
        rd(A_ICRL, d); check("t5_icrl", d, 8'hAB);
        icp = 1'b0;
        run_to(clr_cyc + 32'h3400 - 2);
        icp = 1'b1;
        step(3); check("t5_icr_3400", debug_icr, 16'h3400);
        rd(A_ICRH, d); check("t5_icrh_temp", d, 8'h12);
        icp = 1'b0;
        step($urandom_range(1, 200));
        r = cyc;
        rd(A_TCNTL, d); check("t5_tcntl", d, 32'((r - clr_cyc) & 8'hFF));
        rd(A_TCNTH, d); check("t5_tcnth_temp", d, 32'(((r - clr_cyc) >> 8) & 8'hFF));
        rd(6'h3E, d); check("t5_unmapped", d, 8'h00);
        run_to(clr_cyc + 65534);
        check("t4_tcnt_fffe", debug_tcnt, 32'(exp_tcnt()));
        check("t4_no_ovf_yet", icp_ovf_irq, 1'b0);
        step(1);
        check("t4_tcnt_ffff", debug_tcnt, 32'(exp_tcnt()));
        wr(A_ICFR, 8'h02);  // lands on the wrap edge: set must win
        check("t4_tcnt_wrapped", debug_tcnt, 32'(exp_tcnt()));
        check("t4_ovf_set_wins", icp_ovf_irq, 1'b1);
        wr(A_ICFR, 8'h02);
        check("t4_ovf_cleared", icp_ovf_irq, 1'b0);

        // T6: /64 prescaler
        wr(A_ICCR, 8'h0B); clr_cyc = cyc; div = 64;
        run_to(clr_cyc + 63);
        check("t6_tcnt_63", debug_tcnt, 32'(exp_tcnt()));
        step(1);
        check("t6_tcnt_64", debug_tcnt, 32'(exp_tcnt()));
        for (int i = 0; i < 4; i++) begin
            step($urandom_range(20, 90));
            check($sformatf("t6_tcnt_rand%0d", i), debug_tcnt, 32'(exp_tcnt()));
        end

        // Reset mid-capture
        wr(A_ICCR, 8'h63);
        icp = 1'b1;
        step(1);
        reset = 1'b1;
        step(1);
        check("rst2_tcnt", debug_tcnt, 16'h0);
        check("rst2_icr", debug_icr, 16'h0);
        check("rst2_capt_irq", icp_capt_irq, 1'b0);
        check("rst2_ovf_irq", icp_ovf_irq, 1'b0);
        rd(A_ICCR, d); check("rst2_iccr", d, 8'h00);
        rd(A_ICFR, d); check("rst2_icfr", d, 8'h00);
        reset = 1'b0;
        step(8);
        rd(A_ICFR, d); check("rst2_no_late_capture", d, 8'h00);
        check("rst2_tcnt_stopped", debug_tcnt, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
